// File: rtl/mips_noc_if_pkg.sv
// Shared definitions for the MIPS core <-> NoC network interface.
// Latency: n/a (types, constants and width helpers only).
// Backpressure: n/a.
// Contents: node-ID width helper, flit field offsets, RX FSM state encoding.
package mips_noc_if_pkg;

  // Node address width: one bit minimum, even for a 1- or 2-node mesh.
  function automatic int calc_id_w(input int num_nodes);
    return (num_nodes <= 2) ? 1 : $clog2(num_nodes);
  endfunction

  // Flit layout, MSB first: {dest, src, data}.
  function automatic int calc_flit_w(input int id_w, input int data_w);
    return data_w + 2 * id_w;
  endfunction

  function automatic int dest_lsb(input int id_w, input int data_w);
    return data_w + id_w;
  endfunction

  function automatic int src_lsb(input int data_w);
    return data_w;
  endfunction

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_WAIT = 2'd1,
    RX_DONE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/mips_noc_if_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on rd_dat while !empty.
// Latency: a push at edge N is visible on rd_dat/empty after edge N.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
// Ports: clk, rst (sync, active high), push/wr_dat, pop, rd_dat, full, empty.
module mips_noc_if_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    rd_dat   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty pointers hide stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/mips_noc_if.sv
// Network interface between a pipelined MIPS core and its NoC router port (TX/RX FIFOs, loopback, blocking receive).
// Latency: send visible on noc_tx_* one cycle after accept; receive with data present pulses proc_rx_valid one cycle after req.
// Backpressure: proc_tx_ready drops when the target FIFO is full; noc_rx_ready drops when RX is full or a loopback push owns it.
// Ports: clk/rst; current_node; core send (proc_tx_*), core receive (proc_rx_*, proc_stall);
//        router TX (noc_tx_*), router RX (noc_rx_*); misroute_cnt (saturating count of mis-addressed flits).
module mips_noc_if
  import mips_noc_if_pkg::*;
#(
  parameter int NUM_NODES = 4,
  parameter int DATA_W    = 32,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4,
  parameter int TIMEOUT   = 0,
  localparam int ID_W     = calc_id_w(NUM_NODES),
  localparam int FLIT_W   = calc_flit_w(ID_W, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   current_node,
  input  logic              proc_tx_valid,
  input  logic [ID_W-1:0]   proc_tx_dest,
  input  logic [DATA_W-1:0] proc_tx_data,
  output logic              proc_tx_ready,
  input  logic              proc_rx_req,
  output logic              proc_stall,
  output logic              proc_rx_valid,
  output logic [DATA_W-1:0] proc_rx_data,
  output logic [ID_W-1:0]   proc_rx_src,
  output logic              proc_rx_tmo,
  output logic [FLIT_W-1:0] noc_tx_flit,
  output logic              noc_tx_valid,
  input  logic              noc_tx_ready,
  input  logic [FLIT_W-1:0] noc_rx_flit,
  input  logic              noc_rx_valid,
  output logic              noc_rx_ready,
  output logic [7:0]        misroute_cnt
);

  localparam int RX_W     = DATA_W + ID_W;              // RX entry: {src, data}
  localparam int DEST_LSB = dest_lsb(ID_W, DATA_W);
  localparam int TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [FLIT_W-1:0] tx_head;
  logic [RX_W-1:0]   rx_head, rx_wr_dat;
  logic              loop_sel, loop_push, tx_push, tx_pop;
  logic              rx_acc, rx_good, rx_push, rx_pop;

  rx_state_e         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] rx_dat_q, rx_dat_d;
  logic [ID_W-1:0]   rx_src_q, rx_src_d;
  logic              rx_tmo_q, rx_tmo_d;
  logic [7:0]        mis_cnt_q, mis_cnt_d;

  // Datapath: loopback mux, TX/RX handshakes, misroute filter.
  always_comb begin
    loop_sel      = (proc_tx_dest == current_node);
    loop_push     = proc_tx_valid && loop_sel && !rx_full;
    tx_push       = proc_tx_valid && !loop_sel && !tx_full;
    proc_tx_ready = loop_sel ? !rx_full : !tx_full;
    // Loopback owns the RX write port, so the router is held off that cycle.
    noc_rx_ready  = !rx_full && !loop_push;
    rx_acc        = noc_rx_valid && noc_rx_ready;
    rx_good       = (noc_rx_flit[DEST_LSB +: ID_W] == current_node);
    rx_push       = loop_push || (rx_acc && rx_good);
    // Low flit bits are already {src, data}, matching the RX entry layout.
    rx_wr_dat     = loop_push ? {current_node, proc_tx_data} : noc_rx_flit[RX_W-1:0];
    noc_tx_valid  = !tx_empty;
    noc_tx_flit   = tx_empty ? '0 : tx_head;
    tx_pop        = !tx_empty && noc_tx_ready;
    mis_cnt_d     = mis_cnt_q;
    if (rx_acc && !rx_good && (mis_cnt_q != 8'hFF)) mis_cnt_d = mis_cnt_q + 8'd1;
  end

  // RX FSM next state; proc_rx_req only matters in IDLE.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rx_dat_d = rx_dat_q;
    rx_src_d = rx_src_q;
    rx_tmo_d = rx_tmo_q;
    rx_pop   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (proc_rx_req) begin
          if (!rx_empty) begin
            rx_pop   = 1'b1;
            {rx_src_d, rx_dat_d} = rx_head;
            rx_tmo_d = 1'b0;
            state_d  = RX_DONE;
          end else begin
            timer_d  = '0;
            state_d  = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        if (!rx_empty) begin
          rx_pop   = 1'b1;
          {rx_src_d, rx_dat_d} = rx_head;
          rx_tmo_d = 1'b0;
          state_d  = RX_DONE;
        end else if ((TIMEOUT != 0) && (int'(timer_q) == TIMEOUT - 1)) begin
          rx_dat_d = '0;
          rx_src_d = '0;
          rx_tmo_d = 1'b1;
          state_d  = RX_DONE;
        end else begin
          timer_d  = timer_q + TMR_W'(1);
        end
      end
      RX_DONE: state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  // RX FSM outputs.
  always_comb begin
    proc_stall    = ((state_q == RX_IDLE) && proc_rx_req) || (state_q == RX_WAIT);
    proc_rx_valid = (state_q == RX_DONE);
    proc_rx_tmo   = (state_q == RX_DONE) && rx_tmo_q;
    proc_rx_data  = rx_dat_q;
    proc_rx_src   = rx_src_q;
    misroute_cnt  = mis_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      rx_dat_q  <= '0;
      rx_src_q  <= '0;
      rx_tmo_q  <= 1'b0;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rx_dat_q  <= rx_dat_d;
      rx_src_q  <= rx_src_d;
      rx_tmo_q  <= rx_tmo_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  mips_noc_if_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (tx_push),
    .wr_dat ({proc_tx_dest, current_node, proc_tx_data}),
    .pop    (tx_pop),
    .rd_dat (tx_head),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  mips_noc_if_sync_fifo #(.WIDTH(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (rx_push),
    .wr_dat (rx_wr_dat),
    .pop    (rx_pop),
    .rd_dat (rx_head),
    .full   (rx_full),
    .empty  (rx_empty)
  );

endmodule

// File: tb/tb_mips_noc_if.sv
// Self-checking bench for mips_noc_if: instance A (TIMEOUT=8) and instance B (TIMEOUT=0) share inputs.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: router ready driven directly by the stimulus.
module tb_mips_noc_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  current_node;
  logic        proc_tx_valid;
  logic [1:0]  proc_tx_dest;
  logic [31:0] proc_tx_data;
  logic        proc_rx_req;
  logic        noc_tx_ready;
  logic [35:0] noc_rx_flit;
  logic        noc_rx_valid;

  logic        a_tx_ready, a_stall, a_rx_valid, a_rx_tmo, a_ntx_valid, a_nrx_ready;
  logic [31:0] a_rx_data;
  logic [1:0]  a_rx_src;
  logic [35:0] a_ntx_flit;
  logic [7:0]  a_mis;
  logic        b_tx_ready, b_stall, b_rx_valid, b_rx_tmo, b_ntx_valid, b_nrx_ready;
  logic [31:0] b_rx_data;
  logic [1:0]  b_rx_src;
  logic [35:0] b_ntx_flit;
  logic [7:0]  b_mis;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_noc_if #(.NUM_NODES(4), .DATA_W(32), .TX_DEPTH(4), .RX_DEPTH(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .current_node(current_node),
    .proc_tx_valid(proc_tx_valid), .proc_tx_dest(proc_tx_dest), .proc_tx_data(proc_tx_data),
    .proc_tx_ready(a_tx_ready), .proc_rx_req(proc_rx_req), .proc_stall(a_stall),
    .proc_rx_valid(a_rx_valid), .proc_rx_data(a_rx_data), .proc_rx_src(a_rx_src), .proc_rx_tmo(a_rx_tmo),
    .noc_tx_flit(a_ntx_flit), .noc_tx_valid(a_ntx_valid), .noc_tx_ready(noc_tx_ready),
    .noc_rx_flit(noc_rx_flit), .noc_rx_valid(noc_rx_valid), .noc_rx_ready(a_nrx_ready),
    .misroute_cnt(a_mis)
  );

  mips_noc_if #(.NUM_NODES(4), .DATA_W(32), .TX_DEPTH(4), .RX_DEPTH(4), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .current_node(current_node),
    .proc_tx_valid(proc_tx_valid), .proc_tx_dest(proc_tx_dest), .proc_tx_data(proc_tx_data),
    .proc_tx_ready(b_tx_ready), .proc_rx_req(proc_rx_req), .proc_stall(b_stall),
    .proc_rx_valid(b_rx_valid), .proc_rx_data(b_rx_data), .proc_rx_src(b_rx_src), .proc_rx_tmo(b_rx_tmo),
    .noc_tx_flit(b_ntx_flit), .noc_tx_valid(b_ntx_valid), .noc_tx_ready(noc_tx_ready),
    .noc_rx_flit(noc_rx_flit), .noc_rx_valid(noc_rx_valid), .noc_rx_ready(b_nrx_ready),
    .misroute_cnt(b_mis)
  );

  typedef struct {
    string       name;
    logic        txv;
    logic [1:0]  txd;
    logic [31:0] txdat;
    logic        ntr;
    logic        nrv;
    logic [35:0] nrf;
    logic        req;
    logic        e_txr;
    logic        e_ntv;
    logic [35:0] e_ntf;
    logic        e_nrr;
    logic        e_stall;
    logic        e_rxv;
    logic [31:0] e_rxd;
    logic [1:0]  e_rxs;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs on the falling edge; outputs settle 1 unit later.
  task automatic drive(input logic txv, input logic [1:0] txd, input logic [31:0] txdat,
                       input logic ntr, input logic nrv, input logic [35:0] nrf, input logic req);
    @(negedge clk);
    proc_tx_valid = txv;
    proc_tx_dest  = txd;
    proc_tx_data  = txdat;
    noc_tx_ready  = ntr;
    noc_rx_valid  = nrv;
    noc_rx_flit   = nrf;
    proc_rx_req   = req;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    proc_tx_valid = 1'b0; proc_tx_dest = 2'd0; proc_tx_data = '0;
    noc_tx_ready = 1'b0; noc_rx_valid = 1'b0; noc_rx_flit = '0; proc_rx_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int acc;
    int pulses;
    int stall_cnt;
    logic [35:0] ef;

    current_node = 2'd1;
    do_reset();

    // Reset state (node 1, not-loopback dest 0, all requests low).
    check("rst_tx_ready",  a_tx_ready,  1);
    check("rst_ntx_valid", a_ntx_valid, 0);
    check("rst_ntx_flit",  a_ntx_flit,  0);
    check("rst_nrx_ready", a_nrx_ready, 1);
    check("rst_stall",     a_stall,     0);
    check("rst_rx_valid",  a_rx_valid,  0);
    check("rst_rx_data",   a_rx_data,   0);
    check("rst_rx_src",    a_rx_src,    0);
    check("rst_rx_tmo",    a_rx_tmo,    0);
    check("rst_misroute",  a_mis,       0);

    // Table: basic send, basic receive, loopback vs. router collision.
    //                     name       txv txd   txdat          ntr nrv nrf              req txr ntv e_ntf            nrr stl rxv e_rxd          rxs
    vecs.push_back(vec_t'{"send",      1, 2'd2, 32'hDEADBEEF, 1, 0, 36'h0,          0,  1,  0,  36'h0,           1,  0,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"send_out",  0, 2'd0, 32'h0,        1, 0, 36'h0,          0,  1,  1,  36'h9DEADBEEF,   1,  0,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"send_gone", 0, 2'd0, 32'h0,        1, 0, 36'h0,          0,  1,  0,  36'h0,           1,  0,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"rx_in",     0, 2'd0, 32'h0,        0, 1, 36'h700000055,  0,  1,  0,  36'h0,           1,  0,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"rx_req",    0, 2'd0, 32'h0,        0, 0, 36'h0,          1,  1,  0,  36'h0,           1,  1,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"rx_done",   0, 2'd0, 32'h0,        0, 0, 36'h0,          0,  1,  0,  36'h0,           1,  0,  1,  32'h55,        2'd3});
    vecs.push_back(vec_t'{"rx_idle",   0, 2'd0, 32'h0,        0, 0, 36'h0,          0,  1,  0,  36'h0,           1,  0,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"loop_col",  1, 2'd1, 32'h11,       0, 1, 36'h600000022,  0,  1,  0,  36'h0,           0,  0,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"router_in", 0, 2'd0, 32'h0,        0, 1, 36'h600000022,  0,  1,  0,  36'h0,           1,  0,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"req1",      0, 2'd0, 32'h0,        0, 0, 36'h0,          1,  1,  0,  36'h0,           1,  1,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"got_loop",  0, 2'd0, 32'h0,        0, 0, 36'h0,          0,  1,  0,  36'h0,           1,  0,  1,  32'h11,        2'd1});
    vecs.push_back(vec_t'{"req2",      0, 2'd0, 32'h0,        0, 0, 36'h0,          1,  1,  0,  36'h0,           1,  1,  0,  32'h0,         2'd0});
    vecs.push_back(vec_t'{"got_router",0, 2'd0, 32'h0,        0, 0, 36'h0,          0,  1,  0,  36'h0,           1,  0,  1,  32'h22,        2'd2});

    foreach (vecs[i]) begin
      drive(vecs[i].txv, vecs[i].txd, vecs[i].txdat, vecs[i].ntr, vecs[i].nrv, vecs[i].nrf, vecs[i].req);
      check({vecs[i].name, ".tx_ready"},  a_tx_ready,  vecs[i].e_txr);
      check({vecs[i].name, ".ntx_valid"}, a_ntx_valid, vecs[i].e_ntv);
      if (vecs[i].e_ntv) check({vecs[i].name, ".ntx_flit"}, a_ntx_flit, vecs[i].e_ntf);
      check({vecs[i].name, ".nrx_ready"}, a_nrx_ready, vecs[i].e_nrr);
      check({vecs[i].name, ".stall"},     a_stall,     vecs[i].e_stall);
      check({vecs[i].name, ".rx_valid"},  a_rx_valid,  vecs[i].e_rxv);
      if (vecs[i].e_rxv) begin
        check({vecs[i].name, ".rx_data"}, a_rx_data, vecs[i].e_rxd);
        check({vecs[i].name, ".rx_src"},  a_rx_src,  vecs[i].e_rxs);
        check({vecs[i].name, ".rx_tmo"},  a_rx_tmo,  0);
      end
    end

    // TX FIFO fill with router stalled: four accepted, fifth refused.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'd2, 32'(32'h100 + i), 0, 0, '0, 0);
      check($sformatf("fill%0d.tx_ready", i), a_tx_ready, (i < 4) ? 1 : 0);
    end
    // Full FIFO refuses a push even while the head pops this cycle.
    drive(1, 2'd2, 32'h1FF, 1, 0, '0, 0);
    check("full_pop.tx_ready", a_tx_ready, 0);
    check("full_pop.ntx_valid", a_ntx_valid, 1);
    ef = {2'd2, 2'd1, 32'h100};
    check("drain0.flit", a_ntx_flit, ef);
    for (int i = 1; i < 4; i++) begin
      drive(0, 2'd0, '0, 1, 0, '0, 0);
      ef = {2'd2, 2'd1, 32'(32'h100 + i)};
      check($sformatf("drain%0d.valid", i), a_ntx_valid, 1);
      check($sformatf("drain%0d.flit", i),  a_ntx_flit,  ef);
    end
    drive(0, 2'd0, '0, 1, 0, '0, 0);
    check("drained.ntx_valid", a_ntx_valid, 0);

    // Blocking receive on empty RX: A times out after 9 stall cycles, B keeps waiting.
    do_reset();
    stall_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      drive(0, 2'd0, '0, 0, 0, '0, 1);
      if (a_stall && !a_rx_valid) stall_cnt++;
    end
    check("tmo.stall_cycles", stall_cnt, 9);
    drive(0, 2'd0, '0, 0, 0, '0, 0);
    check("tmo.stall_end", a_stall,    0);
    check("tmo.rx_valid",  a_rx_valid, 1);
    check("tmo.rx_tmo",    a_rx_tmo,   1);
    check("tmo.rx_data",   a_rx_data,  0);
    check("tmo.rx_src",    a_rx_src,   0);
    check("tmo0.stall_k9", b_stall,    1);
    stall_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      drive(0, 2'd0, '0, 0, 0, '0, 0);
      if (b_stall && !b_rx_valid) stall_cnt++;
    end
    check("tmo0.still_waiting", stall_cnt, 10);
    drive(0, 2'd0, '0, 0, 1, {2'd1, 2'd3, 32'hAB}, 0);
    check("tmo0.flit_in_stall", b_stall, 1);
    drive(0, 2'd0, '0, 0, 0, '0, 0);
    check("tmo0.pop_stall",  b_stall,    1);
    check("tmo0.pop_valid",  b_rx_valid, 0);
    drive(0, 2'd0, '0, 0, 0, '0, 0);
    check("tmo0.rx_valid", b_rx_valid, 1);
    check("tmo0.rx_data",  b_rx_data,  32'hAB);
    check("tmo0.rx_src",   b_rx_src,   2'd3);
    check("tmo0.rx_tmo",   b_rx_tmo,   0);
    check("tmo0.stall_off", b_stall,   0);

    // Misrouted flood: all accepted, none stored, counter saturates.
    do_reset();
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      drive(0, 2'd0, '0, 0, 1, {2'd0, 2'd2, 32'(i)}, 0);
      if (a_nrx_ready) acc++;
      if (i == 100) check("mis.cnt100", a_mis, 8'd100);
    end
    drive(0, 2'd0, '0, 0, 0, '0, 0);
    check("mis.accepted", acc, 300);
    check("mis.cnt_a", a_mis, 8'd255);
    check("mis.cnt_b", b_mis, 8'd255);
    drive(0, 2'd0, '0, 0, 0, '0, 1);
    check("mis.req_stall", a_stall, 1);
    drive(0, 2'd0, '0, 0, 0, '0, 1);
    check("mis.empty_wait", a_stall, 1);
    check("mis.no_data", a_rx_valid, 0);

    // Reset in the middle of WAIT: back to IDLE, counter cleared, no late pulse.
    @(negedge clk);
    rst = 1'b1;
    proc_rx_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_wait.stall", a_stall,    0);
    check("rst_wait.cnt",   a_mis,      0);
    check("rst_wait.valid", a_rx_valid, 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 2'd0, '0, 0, 0, '0, 0);
      if (a_rx_valid || a_stall) pulses++;
    end
    check("rst_wait.no_pulse", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
